dmac_regs: RTL

//  AHB-Lite slave register file that programs and observes the DMAC channel. Sits directly

---
 rtl/dmac_regs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmac_regs.sv
// AHB-Lite slave register file for the DMAC channel: engine configuration,
// start/done/interrupt control and peripheral request synchronisers.
module dmac_regs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [7:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [7:0]  preq,
  output logic [31:0] saddr,
  output logic [31:0] daddr,
  output logic [31:0] icra,
  output logic [31:0] icrv,
  output logic [2:0]  ssize,
  output logic [2:0]  dsize,
  output logic [2:0]  sinc,
  output logic [2:0]  dinc,
  output logic [2:0]  irqsrc,
  output logic [7:0]  bsize,
  output logic [7:0]  bcount,
  output logic        wfi,
  output logic        start,
  output logic [7:0]  pirq,
  input  logic        done,
  input  logic        busy,
  output logic        irq
);

  localparam int unsigned RW = 6;
  localparam logic [RW-1:0] OFF_SADDR  = RW'(0);
  localparam logic [RW-1:0] OFF_DADDR  = RW'(1);
  localparam logic [RW-1:0] OFF_CFG    = RW'(2);
  localparam logic [RW-1:0] OFF_SIZE   = RW'(3);
  localparam logic [RW-1:0] OFF_CTRL   = RW'(4);
  localparam logic [RW-1:0] OFF_STATUS = RW'(5);
  localparam logic [RW-1:0] OFF_ICRA   = RW'(6);
  localparam logic [RW-1:0] OFF_ICRV   = RW'(7);
  localparam logic [RW-1:0] OFF_PIRQ   = RW'(8);

  logic [RW-1:0] aph_addr;
  logic          aph_wr;
  logic          aph_vld;
  logic          wr_en;
  logic          cfg_wr;
  logic          start_wr;
  logic          w1c_done;
  logic          ien;
  logic          done_st;
  logic [7:0]    sync_q [SYNC_STAGES];
  logic          unused_in;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_in = ^{HSIZE, HADDR[1:0], HTRANS[0]};

  assign wr_en    = aph_vld & aph_wr;
  assign cfg_wr   = wr_en & ~busy;
  assign start_wr = cfg_wr & (aph_addr == OFF_CTRL) & HWDATA[0];
  assign w1c_done = wr_en & (aph_addr == OFF_STATUS) & HWDATA[1];
  assign pirq     = sync_q[SYNC_STAGES-1];

  // Capture the accepted address phase for use in the following data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_vld  <= 1'b0;
      aph_wr   <= 1'b0;
      aph_addr <= '0;
    end else begin
      aph_vld  <= HSEL & HTRANS[1] & HREADY;
      aph_wr   <= HWRITE;
      aph_addr <= HADDR[7:2];
    end
  end

  // Engine configuration registers, frozen while the engine is busy
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      saddr  <= '0;
      daddr  <= '0;
      icra   <= '0;
      icrv   <= '0;
      ssize  <= '0;
      dsize  <= '0;
      sinc   <= '0;
      dinc   <= '0;
      wfi    <= 1'b0;
      irqsrc <= '0;
      bsize  <= '0;
      bcount <= '0;
    end else if (cfg_wr) begin
      case (aph_addr)
        OFF_SADDR: saddr <= HWDATA;
        OFF_DADDR: daddr <= HWDATA;
        OFF_ICRA:  icra  <= HWDATA;
        OFF_ICRV:  icrv  <= HWDATA;
        OFF_CFG: begin
          ssize  <= HWDATA[2:0];
          dsize  <= HWDATA[6:4];
          sinc   <= HWDATA[10:8];
          dinc   <= HWDATA[14:12];
          wfi    <= HWDATA[16];
          irqsrc <= HWDATA[22:20];
        end
        OFF_SIZE: begin
          bsize  <= HWDATA[7:0];
          bcount <= HWDATA[15:8];
        end
        default: ;
      endcase
    end
  end

  // Start pulse, interrupt enable, sticky done (set beats clear) and irq
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      start   <= 1'b0;
      ien     <= 1'b0;
      done_st <= 1'b0;
      irq     <= 1'b0;
    end else begin
      start <= start_wr;
      if (wr_en && aph_addr == OFF_CTRL) ien <= HWDATA[1];
      if (done) done_st <= 1'b1;
      else if (start_wr || w1c_done) done_st <= 1'b0;
      irq <= done_st & ien;
    end
  end

  // Per-bit synchroniser chains for the raw peripheral requests
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= preq;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Data-phase read mux
  always_comb begin
    HRDATA = '0;
    case (aph_addr)
      OFF_SADDR:  HRDATA = saddr;
      OFF_DADDR:  HRDATA = daddr;
      OFF_CFG:    HRDATA = {9'd0, irqsrc, 3'd0, wfi, 1'b0, dinc, 1'b0, sinc,
                            1'b0, dsize, 1'b0, ssize};
      OFF_SIZE:   HRDATA = {16'd0, bcount, bsize};
      OFF_CTRL:   HRDATA = {30'd0, ien, 1'b0};
      OFF_STATUS: HRDATA = {30'd0, done_st, busy};
      OFF_ICRA:   HRDATA = icra;
      OFF_ICRV:   HRDATA = icrv;
      OFF_PIRQ:   HRDATA = {24'd0, pirq};
      default:    HRDATA = '0;
    endcase
  end

endmodule
